// File: rtl/serial_addsub_digit.sv
// Digit-serial adder/subtractor: one DW-bit digit per accepted cycle,
// LSB digit first, with word-level carry and signed overflow flags.
module serial_addsub_digit #(
   parameter int DW   = 1,
   parameter int NDIG = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          sub,
   input  logic          valid_in,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [DW-1:0] sum,
   output logic          sum_valid,
   output logic          done,
   output logic          carry_out,
   output logic          overflow,
   output logic          busy
);

   localparam int CW = $clog2(NDIG + 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]    state;
   logic          carry;
   logic          mode;
   logic [CW-1:0] cnt;

   logic          accept;
   logic          cin;
   logic          m;
   logic [DW-1:0] bx;
   logic [DW:0]   res;
   logic [CW-1:0] cnt_n;
   logic          last;
   logic          msb_c;

   always_comb begin
      accept = valid_in & (start | (state == RUN));
      cin    = start ? sub : carry;
      m      = start ? sub : mode;
      bx     = b ^ {DW{m}};
      res    = {1'b0, a} + {1'b0, bx} + {{DW{1'b0}}, cin};
      cnt_n  = start ? CW'(1) : cnt + CW'(1);
      last   = (cnt_n == CW'(NDIG));
      // carry into the sign bit, recovered from the sum bit
      msb_c  = a[DW-1] ^ bx[DW-1] ^ res[DW-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         carry     <= 1'b0;
         mode      <= 1'b0;
         cnt       <= '0;
         sum       <= '0;
         sum_valid <= 1'b0;
         done      <= 1'b0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         sum_valid <= accept;
         done      <= accept & last;
         if (accept) begin
            sum   <= res[DW-1:0];
            carry <= res[DW];
            mode  <= m;
            cnt   <= last ? '0 : cnt_n;
            state <= last ? IDLE : RUN;
            if (last) begin
               carry_out <= res[DW];
               overflow  <= msb_c ^ res[DW];
            end
         end
      end
   end

   assign busy = (state == RUN);

endmodule

// File: tb/tb_serial_addsub_digit.sv
// Directed bench for serial_addsub_digit in three digit/word shapes.
// Expected digits and flags are worked out by hand per vector.
module tb_serial_addsub_digit;

   logic clk;
   logic rst_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // DW=4, NDIG=2
   logic       s4_start, s4_sub, s4_vin;
   logic [3:0] s4_a, s4_b, s4_sum;
   logic       s4_sv, s4_done, s4_co, s4_ov, s4_busy;

   // DW=1, NDIG=8
   logic       s1_start, s1_sub, s1_vin;
   logic [0:0] s1_a, s1_b, s1_sum;
   logic       s1_sv, s1_done, s1_co, s1_ov, s1_busy;

   // DW=3, NDIG=1
   logic       s3_start, s3_sub, s3_vin;
   logic [2:0] s3_a, s3_b, s3_sum;
   logic       s3_sv, s3_done, s3_co, s3_ov, s3_busy;

   serial_addsub_digit #(.DW(4), .NDIG(2)) u4 (
      .clk(clk), .rst_n(rst_n), .start(s4_start), .sub(s4_sub),
      .valid_in(s4_vin), .a(s4_a), .b(s4_b), .sum(s4_sum),
      .sum_valid(s4_sv), .done(s4_done), .carry_out(s4_co),
      .overflow(s4_ov), .busy(s4_busy)
   );

   serial_addsub_digit #(.DW(1), .NDIG(8)) u1 (
      .clk(clk), .rst_n(rst_n), .start(s1_start), .sub(s1_sub),
      .valid_in(s1_vin), .a(s1_a), .b(s1_b), .sum(s1_sum),
      .sum_valid(s1_sv), .done(s1_done), .carry_out(s1_co),
      .overflow(s1_ov), .busy(s1_busy)
   );

   serial_addsub_digit #(.DW(3), .NDIG(1)) u3 (
      .clk(clk), .rst_n(rst_n), .start(s3_start), .sub(s3_sub),
      .valid_in(s3_vin), .a(s3_a), .b(s3_b), .sum(s3_sum),
      .sum_valid(s3_sv), .done(s3_done), .carry_out(s3_co),
      .overflow(s3_ov), .busy(s3_busy)
   );

   int n_tests;
   int n_fail;
   int n_done;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // one full 2-digit word on u4; inputs remain valid on exit
   task automatic word4(input string tag, input logic s,
                        input logic [7:0] av, input logic [7:0] bv,
                        input logic [3:0] e0, input logic [3:0] e1,
                        input logic eco, input logic eov);
      logic [3:0] ex [2];
      ex[0] = e0;
      ex[1] = e1;
      for (int d = 0; d < 2; d++) begin
         @(negedge clk);
         s4_start = (d == 0);
         s4_sub   = (d == 0) ? s : 1'b0;
         s4_vin   = 1'b1;
         s4_a     = av[4*d +: 4];
         s4_b     = bv[4*d +: 4];
         @(posedge clk);
         #1;
         chk({tag, ".sum"}, 32'(s4_sum), 32'(ex[d]));
         chk({tag, ".sv"}, 32'(s4_sv), 32'd1);
         chk({tag, ".done"}, 32'(s4_done), 32'(d == 1));
         chk({tag, ".busy"}, 32'(s4_busy), 32'(d == 0));
      end
      chk({tag, ".co"}, 32'(s4_co), 32'(eco));
      chk({tag, ".ov"}, 32'(s4_ov), 32'(eov));
   endtask

   task automatic idle4();
      @(negedge clk);
      s4_vin   = 1'b0;
      s4_start = 1'b0;
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      n_done   = 0;
      rst_n    = 1'b0;
      s4_start = 0; s4_sub = 0; s4_vin = 0; s4_a = 0; s4_b = 0;
      s1_start = 0; s1_sub = 0; s1_vin = 0; s1_a = 0; s1_b = 0;
      s3_start = 0; s3_sub = 0; s3_vin = 0; s3_a = 0; s3_b = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.sum", 32'(s4_sum), 32'd0);
      chk("rst.sv", 32'(s4_sv), 32'd0);
      chk("rst.done", 32'(s4_done), 32'd0);
      chk("rst.co", 32'(s4_co), 32'd0);
      chk("rst.ov", 32'(s4_ov), 32'd0);
      chk("rst.busy", 32'(s4_busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // back-to-back words, no bubble between them
      word4("add35_4a", 1'b0, 8'h35, 8'h4a, 4'hf, 4'h7, 1'b0, 1'b0);
      word4("add7f_01", 1'b0, 8'h7f, 8'h01, 4'h0, 4'h8, 1'b0, 1'b1);
      word4("sub80_01", 1'b1, 8'h80, 8'h01, 4'hf, 4'h7, 1'b1, 1'b1);
      word4("sub05_07", 1'b1, 8'h05, 8'h07, 4'he, 4'hf, 1'b0, 1'b0);
      idle4();

      // stall in IDLE: no accept without start
      s4_vin = 1'b1;
      s4_a   = 4'h3;
      @(posedge clk);
      #1;
      chk("idle.sv", 32'(s4_sv), 32'd0);
      chk("idle.busy", 32'(s4_busy), 32'd0);
      idle4();

      // reset mid-word
      s4_start = 1'b1; s4_sub = 1'b0; s4_vin = 1'b1;
      s4_a = 4'h9; s4_b = 4'h9;
      @(posedge clk);
      #1;
      chk("pre_rst.busy", 32'(s4_busy), 32'd1);
      chk("pre_rst.sum", 32'(s4_sum), 32'h2);
      @(negedge clk);
      s4_vin = 1'b0; s4_start = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst.busy", 32'(s4_busy), 32'd0);
      chk("async_rst.sum", 32'(s4_sum), 32'd0);
      chk("async_rst.sv", 32'(s4_sv), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst.done", 32'(s4_done), 32'd0);
      word4("add12_34", 1'b0, 8'h12, 8'h34, 4'h6, 4'h4, 1'b0, 1'b0);
      idle4();

      // start mid-word: sub leaves carry=1, add restart must use cin=0
      s4_start = 1'b1; s4_sub = 1'b1; s4_vin = 1'b1;
      s4_a = 4'h3; s4_b = 4'h1;
      @(posedge clk);
      #1;
      chk("abort.sum", 32'(s4_sum), 32'h2);
      word4("restart", 1'b0, 8'h35, 8'h4a, 4'hf, 4'h7, 1'b0, 1'b0);
      idle4();

      // DW=1: 0xFF + 0x01 with 1-3 cycle gaps
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         s1_start = (i == 0);
         s1_sub   = 1'b0;
         s1_vin   = 1'b1;
         s1_a     = 1'b1;
         s1_b     = (i == 0) ? 1'b1 : 1'b0;
         @(posedge clk);
         #1;
         if (s1_done) n_done++;
         chk($sformatf("bit%0d.sum", i), 32'(s1_sum), 32'd0);
         chk($sformatf("bit%0d.sv", i), 32'(s1_sv), 32'd1);
         chk($sformatf("bit%0d.done", i), 32'(s1_done), 32'(i == 7));
         for (int g = 0; g < (i % 3) + 1; g++) begin
            @(negedge clk);
            s1_vin   = 1'b0;
            s1_start = 1'b0;
            s1_a     = 1'b0;
            @(posedge clk);
            #1;
            if (s1_done) n_done++;
            chk($sformatf("gap%0d.sv", i), 32'(s1_sv), 32'd0);
            chk($sformatf("gap%0d.busy", i), 32'(s1_busy), 32'(i < 7));
         end
      end
      chk("dw1.ndone", 32'(n_done), 32'd1);
      chk("dw1.co", 32'(s1_co), 32'd1);
      chk("dw1.ov", 32'(s1_ov), 32'd0);

      // NDIG=1: 5+6 = 0b1011, signed -3 + -2 overflows
      @(negedge clk);
      s3_start = 1'b1; s3_sub = 1'b0; s3_vin = 1'b1;
      s3_a = 3'd5; s3_b = 3'd6;
      @(posedge clk);
      #1;
      chk("n1.sum", 32'(s3_sum), 32'd3);
      chk("n1.done", 32'(s3_done), 32'd1);
      chk("n1.co", 32'(s3_co), 32'd1);
      chk("n1.ov", 32'(s3_ov), 32'd1);
      chk("n1.busy", 32'(s3_busy), 32'd0);
      @(negedge clk);
      s3_vin = 1'b0; s3_start = 1'b0;
      @(posedge clk);
      #1;
      chk("n1.done_pulse", 32'(s3_done), 32'd0);
      chk("n1.co_hold", 32'(s3_co), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_addsub_digit.md
SERIAL_ADDSUB_DIGIT -- requirements
Module: serial_addsub_digit

Interface
REQ-001 SHALL have parameter DW, default 1, digit width in bits processed per cycle (>=1).
REQ-002 SHALL have parameter NDIG, default 8, digits per operand word (>=1); word width = DW*NDIG.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  marks the first (least-significant) digit of a new word; sampled only when valid_in=1.
REQ-006 sub  input  1  mode, sampled with start: 0 = A+B, 1 = A-B; held internally for the whole word.
REQ-007 valid_in  input  1  a/b digit present this cycle.
REQ-008 a  input  DW  operand A digit, LSB-digit first.
REQ-009 b  input  DW  operand B digit, LSB-digit first.
REQ-010 sum  output  DW  registered result digit.
REQ-011 sum_valid  output  1  sum holds a new digit (one-cycle pulse per accepted digit).
REQ-012 done  output  1  one-cycle pulse coincident with sum_valid of the final digit.
REQ-013 carry_out  output  1  final-digit carry (sub: 1 = no borrow); valid when done=1, held until next done.
REQ-014 overflow  output  1  two's-complement signed overflow of the word; valid when done=1, held until next done.
REQ-015 busy  output  1  1 while in RUN state.

Function
REQ-016 SHALL implement two states: IDLE and RUN, with a carry register and a digit counter of width clog2(NDIG+1).
REQ-017 Digit accepted when valid_in=1 AND (start=1 OR state=RUN); otherwise inputs are ignored.
REQ-018 Accepted digit with start=1 SHALL use carry-in = sub, latch sub, reset digit counter to 1; start=1 in RUN aborts the current word without done and restarts.
REQ-019 Accepted digit with start=0 SHALL use carry-in = stored carry and latched sub; counter increments.
REQ-020 Per digit: {c,s} = a + (b XOR {DW{sub}}) + carry-in, DW+1-bit result; s registered to sum, c stored as next carry-in.
REQ-021 Latency: sum/sum_valid appear exactly one cycle after the accepting edge.
REQ-022 valid_in=0 in RUN SHALL stall: carry, counter, mode held; sum_valid=0; sum holds last value.
REQ-023 Accepting the NDIG-th digit SHALL assert done with that digit's sum_valid, update carry_out=c and overflow=(carry into digit MSB) XOR c, and return to IDLE.
REQ-024 Carry into digit MSB SHALL be computed as a[DW-1] XOR b'[DW-1] XOR s[DW-1] where b' is the (possibly inverted) b.
REQ-025 IDLE -> RUN on accepted start (NDIG>1); NDIG=1 completes in the start cycle and stays IDLE.
REQ-026 start with simultaneous completion of previous word is impossible (start aborts); start accepted on the cycle after done SHALL begin the next word with no bubble.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, carry=0, counter=0, latched sub=0, sum=0, sum_valid=0, done=0, carry_out=0, overflow=0, busy=0.
REQ-028 Reset mid-word SHALL discard the partial word; no done is produced; first accepted start after release begins cleanly.

Verification
REQ-029 DW=4,NDIG=2, add 0x35+0x4A, digits back-to-back -> sum 0xF then 0x7, done on 2nd, carry_out=0, overflow=0.
REQ-030 DW=4,NDIG=2, add 0x7F+0x01 -> sum 0x0,0x8, carry_out=0, overflow=1; sub 0x80-0x01 -> 0xF,0x7, carry_out=1, overflow=1.
REQ-031 DW=4,NDIG=2, sub 0x05-0x07 -> sum 0xE,0xF, carry_out=0 (borrow), overflow=0.
REQ-032 DW=1,NDIG=8, add 0xFF+0x01 with valid_in=0 gaps of 1-3 cycles between bits -> eight 0 sum bits, done once, carry_out=1, overflow=0; counter/carry unchanged across gaps.
REQ-033 DW=4,NDIG=2: start word, assert rst_n=0 after first digit, release, run 0x12+0x34 -> 0x6,0x4, no spurious done; separately, start=1 mid-word restarts with carry-in=sub.
REQ-034 Random scoreboard, DW in {1,3,8}, NDIG in {1,4,8}, random sub/stalls/back-to-back words -> every word matches reference add/sub, carry and overflow.
